alpha_trim_sort_ctrl: RTL



---
 rtl/alpha_trim_sort_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/alpha_trim_sort_ctrl.sv
// Sequencer for the 25-point sorter of the modified alpha-trimmed mean filter.
// Latency: sort_finish at cycle F -> pix_valid first high at F+N+2 (timeout: 16 cycles after WAIT entry).
// Backpressure: one window in flight; win_ready_o low from accept until pix_valid_o&pix_ready_i.
//
// Ports:
//   clk_i, rst_n_i                      clock, synchronous active-low reset
//   win_valid_i/win_ready_o/win_data_i  5x5 window input, sample i at [i*DW+:DW]
//   sort_sig_o/sort_data_o              one-cycle sorter start and registered window copy
//   sort_finish_i/sequence_sorted_i     sorter done pulse and rank->original index map
//   pix_valid_o/pix_ready_i/pix_data_o  filtered pixel output
//   timeout_err_o                       one-cycle pulse when the sorter never answered
// Optional macro ALPHA_TRIM_CTRL_STATS_EN adds win_cnt_o / tmo_cnt_o saturating counters.
module alpha_trim_sort_ctrl #(
    parameter int DN      = 25,
    parameter int DW      = 8,
    parameter int DW_SEQ  = $clog2(DN),
    parameter int TRIM    = 6,
    parameter int RECIP   = 5041,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 win_valid_i,
    output logic                 win_ready_o,
    input  logic [DW*DN-1:0]     win_data_i,
    output logic                 sort_sig_o,
    output logic [DW*DN-1:0]     sort_data_o,
    input  logic                 sort_finish_i,
    input  logic [DW_SEQ*DN-1:0] sequence_sorted_i,
    output logic                 pix_valid_o,
    input  logic                 pix_ready_i,
    output logic [DW-1:0]        pix_data_o,
    output logic                 timeout_err_o
`ifdef ALPHA_TRIM_CTRL_STATS_EN
    ,
    output logic [15:0]          win_cnt_o,
    output logic [15:0]          tmo_cnt_o
`endif
);

    localparam int AW = DW + $clog2(DN);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_LAUNCH = 6'b000010,
        ST_WAIT   = 6'b000100,
        ST_ACCUM  = 6'b001000,
        ST_SCALE  = 6'b010000,
        ST_OUT    = 6'b100000
    } state_e;

    state_e                state_q, state_d;
    logic [DW*DN-1:0]      sort_data_q, sort_data_d;
    logic [DW_SEQ*DN-1:0]  seq_q, seq_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic [DW_SEQ-1:0]     k_q, k_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [DW-1:0]         pix_data_q, pix_data_d;
    logic                  timeout_err_q, timeout_err_d;

    logic [DW_SEQ-1:0]     rank_idx;
    logic [DW-1:0]         rank_smp;
    logic [31:0]           prod;
    logic [31:0]           scaled;
    logic [DW-1:0]         scaled_sat;

    // Sample of rank k: two plain muxes; an original index >= DN matches no
    // slot and therefore contributes zero to the sum.
    always_comb begin
        rank_idx = '0;
        for (int i = 0; i < DN; i++) begin
            if (k_q == DW_SEQ'(i)) rank_idx = seq_q[i*DW_SEQ +: DW_SEQ];
        end
        rank_smp = '0;
        for (int i = 0; i < DN; i++) begin
            if (rank_idx == DW_SEQ'(i)) rank_smp = sort_data_q[i*DW +: DW];
        end
    end

    // Mean = sum * round(65536/N), rounded half-up back to integer, clamped.
    always_comb begin
        prod   = 32'(acc_q) * 32'(RECIP) + 32'd32768;
        scaled = prod >> 16;
        if (scaled > 32'((1 << DW) - 1)) scaled_sat = '1;
        else                             scaled_sat = scaled[DW-1:0];
    end

    always_comb begin
        state_d       = state_q;
        sort_data_d   = sort_data_q;
        seq_d         = seq_q;
        acc_d         = acc_q;
        k_d           = k_q;
        timer_d       = timer_q;
        pix_data_d    = pix_data_q;
        timeout_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid_i) begin
                    sort_data_d = win_data_i;
                    state_d     = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A finish arriving on the last timer cycle still wins.
                if (sort_finish_i) begin
                    seq_d   = sequence_sorted_i;
                    acc_d   = '0;
                    k_d     = DW_SEQ'(TRIM);
                    state_d = ST_ACCUM;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    pix_data_d    = sort_data_q[(DN/2)*DW +: DW];
                    timeout_err_d = 1'b1;
                    state_d       = ST_OUT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_ACCUM: begin
                acc_d = acc_q + AW'(rank_smp);
                k_d   = k_q + DW_SEQ'(1);
                if (k_q == DW_SEQ'(DN - 1 - TRIM)) state_d = ST_SCALE;
            end
            ST_SCALE: begin
                pix_data_d = scaled_sat;
                state_d    = ST_OUT;
            end
            ST_OUT: begin
                if (pix_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            sort_data_q   <= '0;
            seq_q         <= '0;
            acc_q         <= '0;
            k_q           <= '0;
            timer_q       <= '0;
            pix_data_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sort_data_q   <= sort_data_d;
            seq_q         <= seq_d;
            acc_q         <= acc_d;
            k_q           <= k_d;
            timer_q       <= timer_d;
            pix_data_q    <= pix_data_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Ready is masked by reset so no window is taken while reset is held.
    assign win_ready_o   = rst_n_i && (state_q == ST_IDLE);
    assign sort_sig_o    = (state_q == ST_LAUNCH);
    assign sort_data_o   = sort_data_q;
    assign pix_valid_o   = (state_q == ST_OUT);
    assign pix_data_o    = pix_data_q;
    assign timeout_err_o = timeout_err_q;

`ifdef ALPHA_TRIM_CTRL_STATS_EN
    logic [15:0] win_cnt_q;
    logic [15:0] tmo_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            win_cnt_q <= '0;
            tmo_cnt_q <= '0;
        end else begin
            if (state_q == ST_IDLE && win_valid_i && win_cnt_q != 16'hFFFF)
                win_cnt_q <= win_cnt_q + 16'd1;
            if (timeout_err_d && tmo_cnt_q != 16'hFFFF)
                tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end

    assign win_cnt_o = win_cnt_q;
    assign tmo_cnt_o = tmo_cnt_q;
`endif

endmodule
